// File: rtl/mos_ctrl_seq.sv
// Control sequencer for the MOS/CMOS switch stage: one gated pulse per request
// (data setup with switch off, fixed on window, guard window), all outputs registered.
module mos_ctrl_seq #(
   parameter int SETUP_CYC = 2,
   parameter int ON_CYC    = 4,
   parameter int GUARD_CYC = 1,
   parameter int CNT_W     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  logic data_in,
   output logic din,
   output logic nctrl,
   output logic pctrl,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      ON    = 2'd2,
      GUARD = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;

   // Phase sequencing with outputs computed alongside the next state, so every output is a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         din     <= 1'b0;
         nctrl   <= 1'b0;
         pctrl   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= SETUP;
                  cnt_r   <= CNT_ZERO;
                  din     <= data_in;
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               // abort skips the on window entirely but the guard still runs
               if (abort) begin
                  state_r <= GUARD;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == SETUP_LAST) begin
                  state_r <= ON;
                  cnt_r   <= CNT_ZERO;
                  nctrl   <= 1'b1;
                  pctrl   <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ON: begin
               if (abort || (cnt_r == ON_LAST)) begin
                  state_r <= GUARD;
                  cnt_r   <= CNT_ZERO;
                  nctrl   <= 1'b0;
                  pctrl   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            GUARD: begin
               if (cnt_r == GUARD_LAST) begin
                  state_r <= IDLE;
                  cnt_r   <= CNT_ZERO;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
               nctrl   <= 1'b0;
               pctrl   <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mos_ctrl_seq.sv
// Bench for mos_ctrl_seq: default and minimal-timing instances checked every cycle
// against an interval-based pulse model, plus hand-computed literal expectations.
module tb_mos_ctrl_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start_a, abort_a, data_a, din_a, nctrl_a, pctrl_a, busy_a, done_a;
   logic start_b, abort_b, data_b, din_b, nctrl_b, pctrl_b, busy_b, done_b;

   mos_ctrl_seq dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .data_in(data_a),
      .din(din_a), .nctrl(nctrl_a), .pctrl(pctrl_a), .busy(busy_a), .done(done_a)
   );

   mos_ctrl_seq #(.SETUP_CYC(1), .ON_CYC(1), .GUARD_CYC(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .data_in(data_b),
      .din(din_b), .nctrl(nctrl_b), .pctrl(pctrl_b), .busy(busy_b), .done(done_b)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: each pulse is a set of cycle intervals [t_start, t_done)
   int p_s [2] = '{2, 1};
   int p_o [2] = '{4, 1};
   int p_g [2] = '{1, 1};
   bit m_have [2];
   int m_ts [2];
   int m_ton [2];
   int m_tg [2];
   int m_td [2];
   bit m_din [2];

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_have[d] = 1'b0;
         m_din[d]  = 1'b0;
      end
   endtask

   function automatic bit f_busy(input int d, input int x);
      return m_have[d] && x >= m_ts[d] && x < m_td[d];
   endfunction

   function automatic bit f_on(input int d, input int x);
      return m_have[d] && x >= m_ton[d] && x < m_tg[d];
   endfunction

   function automatic bit f_done(input int d, input int x);
      return m_have[d] && x == m_td[d];
   endfunction

   task automatic model_update(input int d, input logic st, input logic ab, input logic da);
      int now;
      now = cyc;
      if (!f_busy(d, now)) begin
         if (st) begin
            m_have[d] = 1'b1;
            m_ts[d]   = now + 1;
            m_ton[d]  = m_ts[d] + p_s[d];
            m_tg[d]   = m_ton[d] + p_o[d];
            m_td[d]   = m_tg[d] + p_g[d];
            m_din[d]  = da;
         end
      end else if (ab && now < m_tg[d]) begin
         m_tg[d] = now + 1;
         if (m_ton[d] > m_tg[d]) m_ton[d] = m_tg[d];
         m_td[d] = m_tg[d] + p_g[d];
      end
   endtask

   task automatic compare_all();
      chk("a_din",   din_a,   m_din[0]);
      chk("a_nctrl", nctrl_a, f_on(0, cyc));
      chk("a_pctrl", pctrl_a, ~nctrl_a);
      chk("a_busy",  busy_a,  f_busy(0, cyc));
      chk("a_done",  done_a,  f_done(0, cyc));
      chk("b_din",   din_b,   m_din[1]);
      chk("b_nctrl", nctrl_b, f_on(1, cyc));
      chk("b_pctrl", pctrl_b, ~nctrl_b);
      chk("b_busy",  busy_b,  f_busy(1, cyc));
      chk("b_done",  done_b,  f_done(1, cyc));
   endtask

   task automatic step();
      @(posedge clk);
      model_update(0, start_a, abort_a, data_a);
      model_update(1, start_b, abort_b, data_b);
      cyc++;
      #1;
      compare_all();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a_din"},   din_a,   1'b0);
      chk({tag, "_a_nctrl"}, nctrl_a, 1'b0);
      chk({tag, "_a_pctrl"}, pctrl_a, 1'b1);
      chk({tag, "_a_busy"},  busy_a,  1'b0);
      chk({tag, "_a_done"},  done_a,  1'b0);
      chk({tag, "_b_nctrl"}, nctrl_b, 1'b0);
      chk({tag, "_b_pctrl"}, pctrl_b, 1'b1);
      chk({tag, "_b_busy"},  busy_b,  1'b0);
   endtask

   int busy_cnt;
   int done_cnt;
   int on_cnt;

   initial begin
      rst_n = 1'b0;
      {start_a, abort_a, data_a, start_b, abort_b, data_b} = 6'b0;
      model_reset();
      #12;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // single pulse, data 1, literal timeline relative to the start cycle
      data_a = 1'b1;
      for (int k = 0; k < 10; k++) begin
         start_a = (k == 0);
         step();
         chk("t1_din",   din_a,   1'b1);
         chk("t1_nctrl", nctrl_a, (k + 1 >= 3) && (k + 1 <= 6));
         chk("t1_busy",  busy_a,  (k + 1 >= 1) && (k + 1 <= 7));
         chk("t1_done",  done_a,  (k + 1 == 8));
      end

      // start held high: back-to-back pulses every 8 cycles
      start_a  = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 24; k++) begin
         data_a = 1'($urandom_range(0, 1));
         step();
         if (done_a) done_cnt++;
      end
      chk("t2_three_dones", (done_cnt == 3), 1'b1);
      start_a = 1'b0;
      step();
      step();

      // abort in the second ON cycle
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         start_a = (k == 0);
         abort_a = (k == 4);
         step();
         if (busy_a) busy_cnt++;
         if (done_a) done_cnt++;
         if (k == 4) chk("t3_off_after_abort", nctrl_a, 1'b0);
      end
      abort_a = 1'b0;
      chk("t3_busy5", (busy_cnt == 5), 1'b1);
      chk("t3_done1", (done_cnt == 1), 1'b1);

      // minimal-timing instance: on for exactly one cycle
      on_cnt = 0;
      data_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         start_b = (k == 0);
         step();
         if (nctrl_b) on_cnt++;
         if (k == 1) chk("t6_on_cycle2", nctrl_b, 1'b1);
      end
      chk("t6_on_once", (on_cnt == 1), 1'b1);

      // reset mid-ON, asynchronous to clk
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("t5_in_on", nctrl_a, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("arst_no_done", done_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step();

      // randomized traffic on both instances
      for (int k = 0; k < 800; k++) begin
         start_a = ($urandom_range(0, 2) == 0);
         abort_a = ($urandom_range(0, 7) == 0);
         data_a  = 1'($urandom_range(0, 1));
         start_b = ($urandom_range(0, 2) == 0);
         abort_b = ($urandom_range(0, 5) == 0);
         data_b  = 1'($urandom_range(0, 1));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
